// File: rtl/panel_loader.sv
// Front-panel controller: debounces the pushbutton, loads DIP-switch words into
// program memory, and gates the CPU as held reset, single step or free run.
module panel_loader #(
    parameter int PC_WIDTH        = 5,
    parameter int REGISTER_WIDTH  = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DEBOUNCE_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic                      switch,
    input  logic [1:0]                mode,
    input  logic [REGISTER_WIDTH-1:0] dataSwitches,
    output logic                      memWriteEnable,
    output logic [PC_WIDTH-1:0]       memWriteAddress,
    output logic [REGISTER_WIDTH-1:0] memWriteData,
    output logic                      cpuReset,
    output logic                      cpuEnable,
    output logic [PC_WIDTH:0]         loadCount,
    output logic                      full
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_STEP = 2'b01,
        ST_RUN  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [DEBOUNCE_WIDTH-1:0] DEB_LAST   = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_WIDTH-1:0] DEB_ONE    = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0]       ADDR_ONE   = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH:0]         COUNT_ONE  = {{PC_WIDTH{1'b0}}, 1'b1};
    localparam logic [PC_WIDTH:0]         FULL_COUNT = {1'b1, {PC_WIDTH{1'b0}}};

    logic                      switch_meta_r, switch_sync_r;
    logic [1:0]                mode_meta_r, mode_sync_r;
    logic [DEBOUNCE_WIDTH-1:0] deb_count_r;
    logic                      deb_level_r, deb_prev_r;

    state_t                    state_r, next_state_s;
    logic [PC_WIDTH-1:0]       address_r, address_n_s;
    logic [PC_WIDTH:0]         load_count_r, load_count_n_s;
    logic                      full_r, full_n_s;
    logic                      mem_we_r;
    logic [PC_WIDTH-1:0]       mem_addr_r;
    logic [REGISTER_WIDTH-1:0] mem_data_r;
    logic                      cpu_reset_r, cpu_reset_n_s;
    logic                      cpu_enable_r, cpu_enable_n_s;
    logic                      press_s, write_s, step_press_s;

    // Synchronize the button and mode DIPs, then debounce the button level.
    always_ff @(posedge clock) begin
        if (isReset) begin
            switch_meta_r <= 1'b0;
            switch_sync_r <= 1'b0;
            mode_meta_r   <= 2'b00;
            mode_sync_r   <= 2'b00;
            deb_count_r   <= '0;
            deb_level_r   <= 1'b0;
            deb_prev_r    <= 1'b0;
        end else begin
            switch_meta_r <= switch;
            switch_sync_r <= switch_meta_r;
            mode_meta_r   <= mode;
            mode_sync_r   <= mode_meta_r;
            deb_prev_r    <= deb_level_r;
            if (switch_sync_r == deb_level_r) begin
                deb_count_r <= '0;
            end else if (deb_count_r == DEB_LAST) begin
                deb_level_r <= switch_sync_r;
                deb_count_r <= '0;
            end else begin
                deb_count_r <= deb_count_r + DEB_ONE;
            end
        end
    end

    // Next-state and next-output decode; a press is always judged by the registered (old) state.
    always_comb begin
        next_state_s   = state_t'(mode_sync_r);
        press_s        = deb_level_r & ~deb_prev_r;
        write_s        = press_s && (state_r == ST_LOAD) && !full_r;
        step_press_s   = press_s && (state_r == ST_STEP);
        address_n_s    = address_r;
        load_count_n_s = load_count_r;
        full_n_s       = full_r;
        cpu_reset_n_s  = 1'b1;
        cpu_enable_n_s = 1'b0;

        if ((next_state_s == ST_LOAD) && (state_r != ST_LOAD)) begin
            address_n_s    = '0;
            load_count_n_s = '0;
            full_n_s       = 1'b0;
        end else if (write_s) begin
            address_n_s    = address_r + ADDR_ONE;
            load_count_n_s = load_count_r + COUNT_ONE;
            full_n_s       = ((load_count_r + COUNT_ONE) == FULL_COUNT);
        end else begin
            address_n_s    = address_r;
            load_count_n_s = load_count_r;
            full_n_s       = full_r;
        end

        // Outputs follow the incoming state so cpuReset drops with the state change.
        case (next_state_s)
            ST_LOAD: begin
                cpu_reset_n_s  = 1'b1;
                cpu_enable_n_s = 1'b0;
            end
            ST_STEP: begin
                cpu_reset_n_s  = 1'b0;
                cpu_enable_n_s = step_press_s;
            end
            ST_RUN: begin
                cpu_reset_n_s  = 1'b0;
                cpu_enable_n_s = 1'b1;
            end
            ST_HOLD: begin
                cpu_reset_n_s  = 1'b0;
                cpu_enable_n_s = step_press_s;
            end
            default: begin
                cpu_reset_n_s  = 1'b1;
                cpu_enable_n_s = 1'b0;
            end
        endcase
    end

    // State, load counters and registered memory/CPU control outputs.
    always_ff @(posedge clock) begin
        if (isReset) begin
            state_r      <= ST_LOAD;
            address_r    <= '0;
            load_count_r <= '0;
            full_r       <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            cpu_reset_r  <= 1'b1;
            cpu_enable_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            address_r    <= address_n_s;
            load_count_r <= load_count_n_s;
            full_r       <= full_n_s;
            mem_we_r     <= write_s;
            cpu_reset_r  <= cpu_reset_n_s;
            cpu_enable_r <= cpu_enable_n_s;
            if (write_s) begin
                mem_addr_r <= address_r;
                mem_data_r <= dataSwitches;
            end else begin
                mem_addr_r <= mem_addr_r;
                mem_data_r <= mem_data_r;
            end
        end
    end

    assign memWriteEnable  = mem_we_r;
    assign memWriteAddress = mem_addr_r;
    assign memWriteData    = mem_data_r;
    assign cpuReset        = cpu_reset_r;
    assign cpuEnable       = cpu_enable_r;
    assign loadCount       = load_count_r;
    assign full            = full_r;

endmodule

// File: tb/tb_panel_loader.sv
// Directed self-checking bench for panel_loader with a short debounce window.
module tb_panel_loader;

    logic       clock = 1'b0;
    logic       isReset = 1'b1;
    logic       switch = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] dataSwitches = 8'h00;
    logic       memWriteEnable;
    logic [4:0] memWriteAddress;
    logic [7:0] memWriteData;
    logic       cpuReset;
    logic       cpuEnable;
    logic [5:0] loadCount;
    logic       full;

    int checks = 0;
    int passes = 0;

    panel_loader #(
        .PC_WIDTH(5),
        .REGISTER_WIDTH(8),
        .DEBOUNCE_CYCLES(4),
        .DEBOUNCE_WIDTH(16)
    ) dut (
        .clock(clock),
        .isReset(isReset),
        .switch(switch),
        .mode(mode),
        .dataSwitches(dataSwitches),
        .memWriteEnable(memWriteEnable),
        .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData),
        .cpuReset(cpuReset),
        .cpuEnable(cpuEnable),
        .loadCount(loadCount),
        .full(full)
    );

    always #5 clock = ~clock;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        isReset = 1'b1;
        switch  = 1'b0;
        mode    = 2'b00;
        tick();
        tick();
        isReset = 1'b0;
        tick();
    endtask

    // One clean press: hold 12 cycles, release 10; mode may change after race_cyc cycles.
    task automatic press(input logic [7:0] data, input int race_cyc, input logic [1:0] race_mode,
                         output int nwr, output int first, output logic [4:0] waddr,
                         output logic [7:0] wdata, output int nen, output int nrst);
        nwr = 0; first = -1; waddr = 5'd0; wdata = 8'd0; nen = 0; nrst = 0;
        dataSwitches = data;
        switch = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (memWriteEnable) begin
                nwr++;
                if (first < 0) first = c;
                waddr = memWriteAddress;
                wdata = memWriteData;
            end
            if (cpuEnable) nen++;
            if (cpuReset) nrst++;
            if (c == race_cyc) mode = race_mode;
            if (c == 12) switch = 1'b0;
        end
    endtask

    task automatic test_reset();
        int nwr;
        isReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            switch = ~switch;
            tick();
        end
        switch = 1'b0;
        isReset = 1'b0;
        checks++; if (cpuReset !== 1'b1) $display("FAIL reset_cpuReset got %b want 1", cpuReset); else passes++;
        checks++; if ({memWriteEnable, cpuEnable, full} !== 3'b000) $display("FAIL reset_flags got %b want 000", {memWriteEnable, cpuEnable, full}); else passes++;
        checks++; if (memWriteAddress !== 5'd0) $display("FAIL reset_addr got %0d want 0", memWriteAddress); else passes++;
        checks++; if (memWriteData !== 8'h00) $display("FAIL reset_data got %h want 00", memWriteData); else passes++;
        checks++; if (loadCount !== 6'd0) $display("FAIL reset_loadCount got %0d want 0", loadCount); else passes++;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (memWriteEnable) nwr++;
        end
        checks++; if (nwr !== 0) $display("FAIL reset_no_write got %0d writes want 0", nwr); else passes++;
        checks++; if (cpuReset !== 1'b1) $display("FAIL reset_state_load got cpuReset %b want 1", cpuReset); else passes++;
    endtask

    task automatic test_debounce();
        int nwr, first;
        logic [4:0] waddr;
        logic [7:0] wdata;
        logic [3:0] bounce;
        nwr = 0; first = -1; waddr = 5'd0; wdata = 8'd0;
        bounce = 4'b0101;
        dataSwitches = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            switch = bounce[i];
            tick();
            if (memWriteEnable) nwr++;
        end
        switch = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (memWriteEnable) begin
                nwr++;
                if (first < 0) first = c;
                waddr = memWriteAddress;
                wdata = memWriteData;
            end
        end
        switch = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (memWriteEnable) nwr++;
        end
        checks++; if (nwr !== 1) $display("FAIL debounce_count got %0d writes want 1", nwr); else passes++;
        checks++; if (first !== 7) $display("FAIL debounce_latency got %0d want 7", first); else passes++;
        checks++; if ({waddr, wdata} !== {5'd0, 8'h5A}) $display("FAIL debounce_write got %0d/%h want 0/5a", waddr, wdata); else passes++;
    endtask

    task automatic test_load();
        int nwr, first, nen, nrst;
        logic [4:0] waddr;
        logic [7:0] wdata;
        logic [7:0] words [3];
        words[0] = 8'hA1; words[1] = 8'h3C; words[2] = 8'hFF;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            press(words[i], -1, 2'b00, nwr, first, waddr, wdata, nen, nrst);
            checks++;
            if (nwr !== 1 || waddr !== 5'(i) || wdata !== words[i] || nen !== 0)
                $display("FAIL load_write%0d got n=%0d addr=%0d data=%h en=%0d want n=1 addr=%0d data=%h en=0",
                         i, nwr, waddr, wdata, nen, i, words[i]);
            else passes++;
        end
        checks++; if (loadCount !== 6'd3) $display("FAIL load_count got %0d want 3", loadCount); else passes++;
        checks++; if (full !== 1'b0) $display("FAIL load_full got %b want 0", full); else passes++;
    endtask

    task automatic test_full();
        int nwr, first, nen, nrst, bad;
        logic [4:0] waddr;
        logic [7:0] wdata;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            press(8'(i) ^ 8'h96, -1, 2'b00, nwr, first, waddr, wdata, nen, nrst);
            if (nwr !== 1 || waddr !== 5'(i) || wdata !== (8'(i) ^ 8'h96)) begin
                bad++;
                $display("FAIL full_write%0d got n=%0d addr=%0d data=%h", i, nwr, waddr, wdata);
            end
            if (i == 30) begin
                checks++; if (full !== 1'b0) $display("FAIL full_early got %b want 0", full); else passes++;
            end
        end
        checks++; if (bad !== 0) $display("FAIL full_writes got %0d bad want 0", bad); else passes++;
        checks++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else passes++;
        checks++; if (loadCount !== 6'd32) $display("FAIL full_count got %0d want 32", loadCount); else passes++;
        press(8'h77, -1, 2'b00, nwr, first, waddr, wdata, nen, nrst);
        checks++; if (nwr !== 0) $display("FAIL full_33rd got %0d writes want 0", nwr); else passes++;
        checks++; if (loadCount !== 6'd32) $display("FAIL full_count_hold got %0d want 32", loadCount); else passes++;
    endtask

    task automatic test_step_run();
        int nwr, first, nen, nrst, en_cnt, rst_cnt;
        logic [4:0] waddr;
        logic [7:0] wdata;
        apply_reset();
        mode = 2'b01;
        tick(); tick(); tick();
        checks++; if ({cpuReset, cpuEnable} !== 2'b00) $display("FAIL step_entry got %b want 00", {cpuReset, cpuEnable}); else passes++;
        for (int i = 0; i < 2; i++) begin
            press(8'h11, -1, 2'b01, nwr, first, waddr, wdata, nen, nrst);
            checks++;
            if (nen !== 1 || first !== -1 || nwr !== 0 || nrst !== 0)
                $display("FAIL step_pulse%0d got en=%0d wr=%0d rst=%0d want en=1 wr=0 rst=0", i, nen, nwr, nrst);
            else passes++;
        end
        mode = 2'b10;
        tick(); tick(); tick();
        en_cnt = 0; rst_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpuEnable) en_cnt++;
            if (cpuReset) rst_cnt++;
        end
        checks++; if (en_cnt !== 6 || rst_cnt !== 0) $display("FAIL run_enable got en=%0d rst=%0d want 6/0", en_cnt, rst_cnt); else passes++;
        mode = 2'b11;
        tick(); tick(); tick();
        press(8'h22, -1, 2'b11, nwr, first, waddr, wdata, nen, nrst);
        checks++; if (nen !== 0 || nrst !== 0 || nwr !== 0) $display("FAIL hold_frozen got en=%0d rst=%0d wr=%0d want 0/0/0", nen, nrst, nwr); else passes++;
    endtask

    task automatic test_mode_race();
        int nwr, first, nen, nrst;
        logic [4:0] waddr;
        logic [7:0] wdata;
        apply_reset();
        press(8'hC3, 4, 2'b01, nwr, first, waddr, wdata, nen, nrst);
        checks++; if (nwr !== 1 || first !== 7) $display("FAIL race_write got n=%0d at %0d want 1 at 7", nwr, first); else passes++;
        checks++; if (nen !== 0) $display("FAIL race_no_enable got %0d want 0", nen); else passes++;
        checks++; if (loadCount !== 6'd1 || cpuReset !== 1'b0) $display("FAIL race_step got cnt=%0d rst=%b want 1/0", loadCount, cpuReset); else passes++;
        mode = 2'b00;
        tick(); tick(); tick();
        checks++; if (loadCount !== 6'd0 || cpuReset !== 1'b1) $display("FAIL reload_clear got cnt=%0d rst=%b want 0/1", loadCount, cpuReset); else passes++;
        press(8'h0F, -1, 2'b00, nwr, first, waddr, wdata, nen, nrst);
        checks++; if (nwr !== 1 || waddr !== 5'd0 || wdata !== 8'h0F) $display("FAIL reload_addr got n=%0d addr=%0d data=%h want 1/0/0f", nwr, waddr, wdata); else passes++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_load();
        test_full();
        test_step_run();
        test_mode_race();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
